// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control slice: state encodings, time word
// width and the button bit positions, which also fix the event priority.
package stopwatch_pkg;

    localparam int TIME_W = 36;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_RUN   = 2'b01;
    localparam state_t ST_PAUSE = 2'b10;
    localparam state_t ST_LAPV  = 2'b11;

    // Bit positions in the 4-bit button vector; a higher index means higher priority.
    localparam int BTN_LAP   = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;
    localparam int BTN_CLEAR = 3;
    localparam int BTN_N     = 4;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its surroundings
// (debouncers and tick divider in, counter and display mux out).
interface stopwatch_ctrl_if #(
    parameter int TIME_W    = 36,
    parameter int LAP_CNT_W = 4
);
    logic                 tick_1ms_i;
    logic                 start;
    logic                 stop;
    logic                 lap;
    logic                 clear;
    logic [TIME_W-1:0]    time_i;
    logic                 count_en_o;
    logic                 count_clr_o;
    logic [TIME_W-1:0]    disp_o;
    logic [TIME_W-1:0]    lap_o;
    logic [LAP_CNT_W-1:0] lap_cnt_o;
    logic [1:0]           state_o;

    modport master (
        output tick_1ms_i, start, stop, lap, clear, time_i,
        input  count_en_o, count_clr_o, disp_o, lap_o, lap_cnt_o, state_o
    );

    modport slave (
        input  tick_1ms_i, start, stop, lap, clear, time_i,
        output count_en_o, count_clr_o, disp_o, lap_o, lap_cnt_o, state_o
    );
endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Registered rising-edge detector. History resets to all-ones so a button held
// through reset produces no event when reset is released.
module btn_edge #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst,
    input  logic [W-1:0] level_i,
    output logic [W-1:0] evt_o
);
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    always_comb begin
        prev_d = level_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst) prev_q <= '1;
        else     prev_q <= prev_d;
    end

    assign evt_o = level_i & ~prev_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns button events into counter enable/clear,
// captures lap times and reverts a held lap display after LAP_HOLD_MS ticks.
module stopwatch_ctrl #(
    parameter int TIME_W      = 36,
    parameter int LAP_HOLD_MS = 3000,
    parameter int LAP_CNT_W   = 4
) (
    input  logic       clk_i,
    input  logic       resetn,
    stopwatch_ctrl_if.slave sw
);
    import stopwatch_pkg::*;

    localparam logic [15:0] HOLD_LAST = 16'(LAP_HOLD_MS - 1);
    localparam logic [LAP_CNT_W-1:0] CNT_ONE = {{(LAP_CNT_W-1){1'b0}}, 1'b1};

    logic [BTN_N-1:0] btn_level;
    logic [BTN_N-1:0] btn_evt;

    state_t               state_q,   state_d;
    logic                 en_q,      en_d;
    logic                 clr_q,     clr_d;
    logic [TIME_W-1:0]    lap_q,     lap_d;
    logic [LAP_CNT_W-1:0] lap_cnt_q, lap_cnt_d;
    logic [15:0]          hold_q,    hold_d;

    always_comb begin
        btn_level            = '0;
        btn_level[BTN_LAP]   = sw.lap;
        btn_level[BTN_START] = sw.start;
        btn_level[BTN_STOP]  = sw.stop;
        btn_level[BTN_CLEAR] = sw.clear;
    end

    btn_edge #(.W(BTN_N)) u_btn_edge (
        .clk_i   (clk_i),
        .rst     (resetn),
        .level_i (btn_level),
        .evt_o   (btn_evt)
    );

    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        lap_d     = lap_q;
        lap_cnt_d = lap_cnt_q;
        hold_d    = hold_q;

        // Each branch checks only the events legal in that state, highest priority first.
        case (state_q)
            ST_IDLE: begin
                if (btn_evt[BTN_CLEAR])      clr_d   = 1'b1;
                else if (btn_evt[BTN_START]) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (btn_evt[BTN_STOP]) begin
                    state_d = ST_PAUSE;
                end else if (btn_evt[BTN_LAP]) begin
                    state_d   = ST_LAPV;
                    lap_d     = sw.time_i;
                    lap_cnt_d = (lap_cnt_q == '1) ? lap_cnt_q : lap_cnt_q + CNT_ONE;
                    hold_d    = '0;
                end
            end
            ST_PAUSE: begin
                if (btn_evt[BTN_CLEAR]) begin
                    state_d   = ST_IDLE;
                    clr_d     = 1'b1;
                    lap_d     = '0;
                    lap_cnt_d = '0;
                end else if (btn_evt[BTN_START]) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (btn_evt[BTN_STOP]) begin
                    state_d = ST_PAUSE;
                    hold_d  = '0;
                end else if (btn_evt[BTN_LAP]) begin
                    lap_d     = sw.time_i;
                    lap_cnt_d = (lap_cnt_q == '1) ? lap_cnt_q : lap_cnt_q + CNT_ONE;
                    hold_d    = '0;
                end else if (sw.tick_1ms_i && hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else if (sw.tick_1ms_i) begin
                    hold_d = hold_q + 16'd1;
                end
            end
        endcase

        en_d = (state_d == ST_RUN) || (state_d == ST_LAPV);
    end

    always_ff @(posedge clk_i) begin
        if (resetn) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            lap_q     <= '0;
            lap_cnt_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            clr_q     <= clr_d;
            lap_q     <= lap_d;
            lap_cnt_q <= lap_cnt_d;
            hold_q    <= hold_d;
        end
    end

    assign sw.count_en_o  = en_q;
    assign sw.count_clr_o = clr_q;
    assign sw.lap_o       = lap_q;
    assign sw.lap_cnt_o   = lap_cnt_q;
    assign sw.state_o     = state_q;
    assign sw.disp_o      = (state_q == ST_LAPV) ? lap_q : sw.time_i;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 5 ms lap hold.
module tb_stopwatch_ctrl;
    localparam int TW = 36;
    localparam int CW = 4;

    logic clk_i  = 1'b0;
    logic resetn = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    stopwatch_ctrl_if #(.TIME_W(TW), .LAP_CNT_W(CW)) sw ();

    stopwatch_ctrl #(.TIME_W(TW), .LAP_HOLD_MS(5), .LAP_CNT_W(CW)) dut (
        .clk_i  (clk_i),
        .resetn (resetn),
        .sw     (sw.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press_lap();
        sw.lap = 1'b1; step(); sw.lap = 1'b0;
    endtask

    task automatic tick_idle();
        sw.tick_1ms_i = 1'b1; step(); sw.tick_1ms_i = 1'b0; step();
    endtask

    initial begin
        sw.tick_1ms_i = 1'b0;
        sw.start = 1'b1;
        sw.stop  = 1'b0;
        sw.lap   = 1'b0;
        sw.clear = 1'b0;
        sw.time_i = '0;

        // Reset with start held.
        step(); step(); step();
        chk("rst_state",   64'(sw.state_o),     64'h0);
        chk("rst_en",      64'(sw.count_en_o),  64'h0);
        chk("rst_clr",     64'(sw.count_clr_o), 64'h0);
        chk("rst_lap",     64'(sw.lap_o),       64'h0);
        chk("rst_lapcnt",  64'(sw.lap_cnt_o),   64'h0);
        resetn = 1'b0;
        step(); step();
        chk("held_start_no_run", 64'(sw.state_o), 64'h0);
        sw.start = 1'b0; step();
        sw.start = 1'b1; step(); sw.start = 1'b0;
        chk("start_run",   64'(sw.state_o),    64'h1);
        chk("start_en",    64'(sw.count_en_o), 64'h1);

        // Lap capture in RUN.
        sw.time_i = 36'h000012345;
        press_lap();
        chk("lap1_val",    64'(sw.lap_o),      64'h000012345);
        chk("lap1_cnt",    64'(sw.lap_cnt_o),  64'h1);
        chk("lap1_state",  64'(sw.state_o),    64'h3);
        chk("lap1_en",     64'(sw.count_en_o), 64'h1);
        sw.time_i = 36'h000012346; #1;
        chk("lap1_disp_frozen", 64'(sw.disp_o), 64'h000012345);

        // Hold expiry after five ticks.
        for (int i = 0; i < 4; i++) tick_idle();
        chk("hold4_state", 64'(sw.state_o), 64'h3);
        sw.tick_1ms_i = 1'b1; step(); sw.tick_1ms_i = 1'b0;
        chk("hold5_state", 64'(sw.state_o),    64'h1);
        chk("hold5_disp",  64'(sw.disp_o),     64'h000012346);
        chk("hold5_en",    64'(sw.count_en_o), 64'h1);

        // Lap on the expiring tick wins and restarts the hold.
        sw.time_i = 36'h000020000;
        press_lap();
        chk("lap2_cnt", 64'(sw.lap_cnt_o), 64'h2);
        for (int i = 0; i < 4; i++) tick_idle();
        sw.time_i = 36'h000030000;
        sw.tick_1ms_i = 1'b1; sw.lap = 1'b1; step();
        sw.tick_1ms_i = 1'b0; sw.lap = 1'b0;
        chk("lap3_state", 64'(sw.state_o),   64'h3);
        chk("lap3_cnt",   64'(sw.lap_cnt_o), 64'h3);
        chk("lap3_val",   64'(sw.lap_o),     64'h000030000);
        step();
        for (int i = 0; i < 4; i++) tick_idle();
        chk("lap3_hold4_state", 64'(sw.state_o), 64'h3);
        sw.tick_1ms_i = 1'b1; step(); sw.tick_1ms_i = 1'b0;
        chk("lap3_hold5_state", 64'(sw.state_o), 64'h1);

        // Clear ignored in RUN; stop and resume.
        sw.clear = 1'b1; step(); sw.clear = 1'b0;
        chk("run_clear_state", 64'(sw.state_o),     64'h1);
        chk("run_clear_clr",   64'(sw.count_clr_o), 64'h0);
        sw.stop = 1'b1; step(); sw.stop = 1'b0;
        chk("stop_state", 64'(sw.state_o),    64'h2);
        chk("stop_en",    64'(sw.count_en_o), 64'h0);
        sw.start = 1'b1; step(); sw.start = 1'b0;
        chk("resume_state", 64'(sw.state_o),     64'h1);
        chk("resume_clr",   64'(sw.count_clr_o), 64'h0);
        chk("resume_lap",   64'(sw.lap_o),       64'h000030000);

        // Stop from LAPV reverts display to live time.
        sw.time_i = 36'h000040000;
        press_lap();
        sw.time_i = 36'h000040001;
        sw.stop = 1'b1; step(); sw.stop = 1'b0;
        chk("lapv_stop_state", 64'(sw.state_o), 64'h2);
        chk("lapv_stop_disp",  64'(sw.disp_o),  64'h000040001);
        chk("lapv_stop_cnt",   64'(sw.lap_cnt_o), 64'h4);

        // Clear beats start in PAUSE.
        sw.clear = 1'b1; sw.start = 1'b1; step();
        sw.clear = 1'b0; sw.start = 1'b0;
        chk("pclr_clr",    64'(sw.count_clr_o), 64'h1);
        chk("pclr_cnt",    64'(sw.lap_cnt_o),   64'h0);
        chk("pclr_lap",    64'(sw.lap_o),       64'h0);
        chk("pclr_state",  64'(sw.state_o),     64'h0);
        chk("pclr_en",     64'(sw.count_en_o),  64'h0);
        step();
        chk("pclr_pulse_end", 64'(sw.count_clr_o), 64'h0);

        // Clear in IDLE pulses without leaving IDLE.
        sw.clear = 1'b1; step(); sw.clear = 1'b0;
        chk("iclr_clr",   64'(sw.count_clr_o), 64'h1);
        chk("iclr_state", 64'(sw.state_o),     64'h0);
        step();

        // Lap counter saturation, then reset mid-LAPV.
        sw.start = 1'b1; step(); sw.start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sw.time_i = 36'(i + 1);
            press_lap();
            step();
        end
        chk("sat_cnt",   64'(sw.lap_cnt_o), 64'hF);
        chk("sat_lap",   64'(sw.lap_o),     64'h11);
        chk("sat_state", 64'(sw.state_o),   64'h3);
        resetn = 1'b1; step();
        chk("mid_rst_state", 64'(sw.state_o),     64'h0);
        chk("mid_rst_en",    64'(sw.count_en_o),  64'h0);
        chk("mid_rst_clr",   64'(sw.count_clr_o), 64'h0);
        chk("mid_rst_lap",   64'(sw.lap_o),       64'h0);
        chk("mid_rst_cnt",   64'(sw.lap_cnt_o),   64'h0);
        chk("mid_rst_disp",  64'(sw.disp_o),      64'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
